// File: rtl/mux4_scan_sequencer_if.sv
// Bus between the 4:1 mux scan sequencer and its surroundings.
// The master side is the sequencer; the slave side is the environment
// (mux data path, scan requester and snapshot consumer).
//
// Snapshot handshake: the sequencer raises valid with snap and holds both
// stable until the consumer has ready=1 on a rising edge while valid=1.
// That edge is the transfer. valid does not drop and snap does not change
// before it. ready is ignored while valid=0, and the consumer may hold ready
// high before valid rises.
interface mux4_scan_sequencer_if;
    logic       start;  // one-cycle scan request
    logic [3:0] mask;   // channel enables, bit i = channel i
    logic       O_in;   // mux output O
    logic       S;      // mux select MSB
    logic       T;      // mux select LSB
    logic [3:0] snap;   // snapshot word
    logic       valid;  // snap is valid
    logic       ready;  // consumer accepts snap
    logic       busy;   // sequencer is not idle

    modport master (
        input  start, mask, O_in, ready,
        output S, T, snap, valid, busy
    );

    modport slave (
        output start, mask, O_in, ready,
        input  S, T, snap, valid, busy
    );
endinterface

// File: rtl/mux4_scan_sequencer.sv
// Round-robin scan controller for a decoder-based 4:1 multiplexer.
// Steps the select pair {S,T} through the enabled channels in ascending
// order, holds each channel for DWELL cycles, samples O on the last edge of
// each dwell and delivers the four samples as one snapshot over valid/ready.
//
// Build option MUX4_SCAN_CONTINUOUS_EN: when defined, each completed
// handshake immediately launches a new scan with the last captured mask and
// the sequencer only returns to IDLE through reset. When undefined, the
// sequencer is single-shot and waits in IDLE for the next start.
module mux4_scan_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    mux4_scan_sequencer_if.master        scan_if,
    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter reload value; the counter runs DWELL-1 down to 0, so a
    // channel stays selected for exactly DWELL cycles.
    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] snap_q, snap_d;
    logic       valid_q, valid_d;

    logic [3:0] launch_mask;
    logic [2:0] launch_hit;
    logic [2:0] next_hit;

    // Lowest enabled channel whose index is >= from.
    // Returns {found, index}; from may be 4, which never finds anything.
    function automatic logic [2:0] next_above(input logic [3:0] m,
                                              input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    // A fresh scan uses the live mask from IDLE; a back-to-back relaunch
    // from HOLD reuses the mask captured for the previous scan.
    assign launch_mask = (state_q == ST_IDLE) ? scan_if.mask : mask_q;
    assign launch_hit  = next_above(launch_mask, 3'd0);
    assign next_hit    = next_above(mask_q, {1'b0, ch_q} + 3'd1);

    // Next-state and datapath decisions for the scan FSM.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        valid_d  = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_if.start) begin
                    mask_d   = scan_if.mask;
                    shadow_d = 4'b0000;
                    if (launch_hit[2]) begin
                        state_d = ST_SETTLE;
                        ch_d    = launch_hit[1:0];
                        cnt_d   = DWELL_LOAD;
                    end else begin
                        // Nothing to scan: publish an all-zero snapshot.
                        state_d = ST_HOLD;
                        snap_d  = 4'b0000;
                        valid_d = 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    shadow_d[ch_q] = scan_if.O_in;
                    if (next_hit[2]) begin
                        // Hop straight to the next channel, no gap cycle.
                        ch_d  = next_hit[1:0];
                        cnt_d = DWELL_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        ch_d    = 2'd0;
                        snap_d  = shadow_d;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_HOLD: begin
                if (scan_if.ready) begin
`ifdef MUX4_SCAN_CONTINUOUS_EN
                    shadow_d = 4'b0000;
                    if (launch_hit[2]) begin
                        state_d = ST_SETTLE;
                        ch_d    = launch_hit[1:0];
                        cnt_d   = DWELL_LOAD;
                        valid_d = 1'b0;
                    end else begin
                        // Empty mask: every handshake yields another zero word.
                        state_d = ST_HOLD;
                        snap_d  = 4'b0000;
                        valid_d = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ch_d    = 2'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 8'd0;
            mask_q   <= 4'b0000;
            shadow_q <= 4'b0000;
            snap_q   <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
        end
    end

    // Outputs are driven straight from registers; select is forced to 00
    // outside SETTLE so the mux parks on channel A.
    always_comb begin
        scan_if.S     = 1'b0;
        scan_if.T     = 1'b0;
        if (state_q == ST_SETTLE) begin
            scan_if.S = ch_q[1];
            scan_if.T = ch_q[0];
        end
        scan_if.snap  = snap_q;
        scan_if.valid = valid_q;
        scan_if.busy  = (state_q != ST_IDLE);
        dbg_state_o   = state_q;
    end

    // Structural invariants of the scan FSM.
    a_valid_iff_hold: assert property (@(posedge clk) disable iff (rst)
        valid_q == (state_q == ST_HOLD));
    a_settle_on_enabled: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_SETTLE) |-> mask_q[ch_q]);
    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_SETTLE) |-> (cnt_q <= DWELL_LOAD));
    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        state_q != 2'd3);

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Bench for mux4_scan_sequencer (default single-shot build).
// The bench plays the mux (O_in follows the selected channel's data bit) and
// the consumer. Expected snapshots, their arrival cycle and the expected
// select sequence are derived from mask/data at issue time and queued; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_mux4_scan_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    mux4_scan_sequencer_if sif();

    mux4_scan_sequencer #(.DWELL(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_if     (sif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];     // expected snapshot words
    int         exp_t_q[$];   // expected negedge count where valid is first seen
    logic [1:0] sel_q[$];     // expected {S,T} for every busy scan cycle
    logic [3:0] data_cur;     // channel data the mux model presents
    int         ncyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       prev_valid = 1'b0;
    logic [3:0] cur_snap = 4'b0;
    logic [3:0] key, prev_key = 4'hF;
    int         run = 0;
    logic [1:0] sel;
    int         t_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor + mux model ----------------
    always @(negedge clk) begin
        ncyc++;
        sel = {sif.S, sif.T};
        if (rst) begin
            prev_valid = 1'b0;
            prev_key   = 4'hF;
            run        = 0;
        end else begin
            if (sif.busy && !sif.valid) begin
                if (sel_q.size() == 0) fail_now("select_unexpected");
                else check("select", sel, sel_q.pop_front());
            end else begin
                check("select_parked", sel, 2'b00);
            end
            if (sif.valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("snapshot_unexpected");
                end else begin
                    cur_snap = exp_q.pop_front();
                    t_exp    = exp_t_q.pop_front();
                    check("snap", sif.snap, cur_snap);
                    check("valid_latency", ncyc, t_exp);
                end
            end else if (sif.valid) begin
                check("snap_stable", sif.snap, cur_snap);
            end
            prev_valid = sif.valid;
            key = {sif.valid, sif.busy, sel};
            if (key == prev_key) run++;
            else run = 0;
            prev_key = key;
        end
        // The true data bit appears only in the final dwell cycle, so an
        // early or late sample reads the inverted value.
        if (sif.busy && !sif.valid && run == D - 1) sif.O_in = data_cur[sel];
        else sif.O_in = ~data_cur[sel];
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [3:0] m, input logic [3:0] data);
        for (int c = 0; c < 4; c++) begin
            if (m[c]) repeat (D) sel_q.push_back(2'(c));
        end
        exp_q.push_back(data & m);
        exp_t_q.push_back(ncyc + $countones(m) * D + 2);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sif.start = 1'b0;
        sif.ready = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        sel_q.delete();
        @(posedge clk); #1;
        check({tag, "_S"}, sif.S, 1'b0);
        check({tag, "_T"}, sif.T, 1'b0);
        check({tag, "_snap"}, sif.snap, 4'b0000);
        check({tag, "_valid"}, sif.valid, 1'b0);
        check({tag, "_busy"}, sif.busy, 1'b0);
        check({tag, "_state"}, dbg_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one scan, wait for the snapshot, then complete the handshake
    // after rdly cycles of backpressure. pulse fires a stray start mid-scan.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] data,
                            input int rdly, input bit pulse);
        int  n;
        bit  got;
        n = $countones(m);
        data_cur = data;
        push_expect(m, data);
        sif.mask  = m;
        sif.start = 1'b1;
        sif.ready = (rdly == 0);
        @(posedge clk); #1;
        sif.start = 1'b0;
        sif.mask  = 4'($urandom_range(0, 15));
        got = 1'b0;
        for (int i = 0; i < n * D + 8; i++) begin
            if (sif.valid) begin
                got = 1'b1;
                break;
            end
            sif.start = (pulse && i == 1);
            @(posedge clk); #1;
        end
        sif.start = 1'b0;
        if (!got) begin
            fail_now("valid_timeout");
            do_reset("recover");
            return;
        end
        check("sel_drained", sel_q.size(), 0);
        check("busy_in_hold", sif.busy, 1'b1);
        if (rdly > 0) begin
            repeat (rdly) begin
                @(posedge clk); #1;
                check("valid_held", sif.valid, 1'b1);
            end
            sif.ready = 1'b1;
        end
        @(posedge clk); #1;
        sif.ready = 1'b0;
        check("hs_valid_fall", sif.valid, 1'b0);
        check("hs_idle", sif.busy, 1'b0);
        if (pulse) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("no_rescan", sif.busy, 1'b0);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        sif.start = 1'b0;
        sif.mask  = 4'b0000;
        sif.ready = 1'b0;
        sif.O_in  = 1'b0;
        data_cur  = 4'b0000;
        do_reset("reset");

        run_scan(4'b1111, 4'b1101, 0, 1'b0);             // full scan
        run_scan(4'b1010, 4'b1111, 0, 1'b0);             // sparse mask
        run_scan(4'b0000, 4'($urandom_range(0, 15)), 0, 1'b0); // zero mask
        run_scan(4'b1111, 4'($urandom_range(0, 15)), 10, 1'b1); // backpressure + stray start
        run_scan(4'b1000, 4'b1000, 0, 1'b0);             // only the top channel
        run_scan(4'b0001, 4'b0000, 2, 1'b0);             // only channel A, sample 0

        for (int k = 0; k < 24; k++) begin
            run_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the channel-2 dwell.
        data_cur = 4'($urandom_range(0, 15));
        push_expect(4'b1111, data_cur);
        sif.mask  = 4'b1111;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (2 * D + 1) @(posedge clk);
        #1;
        check("pre_reset_sel", {sif.S, sif.T}, 2'b10);
        do_reset("midscan_reset");
        repeat (5) begin
            @(posedge clk); #1;
            check("no_snap_after_reset", sif.valid, 1'b0);
            check("idle_after_reset", sif.busy, 1'b0);
        end

        run_scan(4'b0110, 4'($urandom_range(0, 15)), 1, 1'b0); // recovery

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("sel_q_drained", sel_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
